multi_word_add_ctrl: RTL and testbench



---
 rtl/multi_word_add_pkg.sv | 23 ++
 rtl/multi_word_add_ctrl_nibble_adder.sv | 24 ++
 rtl/multi_word_add_ctrl.sv | 165 ++++++++++++++++
 tb/tb_multi_word_add_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_word_add_pkg.sv
// Shared definitions for the nibble-serial multi-word adder: slice width,
// controller state encoding and the counter width helper.
package multi_word_add_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Ceiling log2 with a floor of one bit so a single-slice counter still exists.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/multi_word_add_ctrl_nibble_adder.sv
// Combinational 4-bit ripple-carry slice built from full-adder cells; the
// controller reuses this single slice once per nibble.
module nibble_adder
  import multi_word_add_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               ci,
  output logic [SLICE_W-1:0] s,
  output logic               co
);

  logic [SLICE_W:0] c_s;

  assign c_s[0] = ci;

  for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
    assign s[i]       = a[i] ^ b[i] ^ c_s[i];
    assign c_s[i + 1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
  end

  assign co = c_s[SLICE_W];

endmodule

// File: rtl/multi_word_add_ctrl.sv
// Nibble-serial WIDTH-bit adder with valid/ready on both sides, LSB nibble first.
// Optional subtract mode (sub_in port) is enabled by defining MULTI_WORD_ADD_SUB_EN.
module multi_word_add_ctrl
  import multi_word_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
`ifdef MULTI_WORD_ADD_SUB_EN
  input  logic             sub_in,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int CNT_W  = clog2(NSLICE);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

  if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
    $error("multi_word_add_ctrl: WIDTH must be a positive multiple of 4");
  end

  state_e             state_r;
  state_e             state_nxt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   a_sh_r;
  logic [WIDTH-1:0]   b_sh_r;
  logic [WIDTH-1:0]   sum_r;
  logic               carry_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic               busy_r;
  logic               accept_s;
  logic               step_s;
  logic [WIDTH-1:0]   b_load_s;
  logic               c_load_s;
  logic [SLICE_W-1:0] slice_s;
  logic               slice_co_s;
  logic [WIDTH-1:0]   sum_shift_s;

  nibble_adder u_slice (
    .a  (a_sh_r[SLICE_W-1:0]),
    .b  (b_sh_r[SLICE_W-1:0]),
    .ci (carry_r),
    .s  (slice_s),
    .co (slice_co_s)
  );

  // New nibble enters at the top so after NSLICE steps the word is in place.
  if (NSLICE == 1) begin : g_one_slice
    assign sum_shift_s = slice_s;
  end else begin : g_multi_slice
    assign sum_shift_s = {slice_s, sum_r[WIDTH-1:SLICE_W]};
  end

  // Operand conditioning at accept: subtract stores ~B and forces carry-in to 1.
  always_comb begin
    b_load_s = b_in;
    c_load_s = c_in;
`ifdef MULTI_WORD_ADD_SUB_EN
    if (sub_in) begin
      b_load_s = ~b_in;
      c_load_s = 1'b1;
    end else begin
      b_load_s = b_in;
      c_load_s = c_in;
    end
`endif
  end

  // Next-state and datapath strobes.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    step_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready_r) begin
          accept_s    = 1'b1;
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        step_s = 1'b1;
        if (cnt_r == LAST_CNT) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register plus handshake/status flags registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == IDLE);
      out_valid_r <= (state_nxt_s == DONE);
      busy_r      <= (state_nxt_s != IDLE);
    end
  end

  // Operand shifters, running carry, slice counter and result accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_r  <= {WIDTH{1'b0}};
      b_sh_r  <= {WIDTH{1'b0}};
      sum_r   <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      a_sh_r  <= a_in;
      b_sh_r  <= b_load_s;
      carry_r <= c_load_s;
      cnt_r   <= {CNT_W{1'b0}};
    end else if (step_s) begin
      a_sh_r  <= a_sh_r >> SLICE_W;
      b_sh_r  <= b_sh_r >> SLICE_W;
      sum_r   <= sum_shift_s;
      carry_r <= slice_co_s;
      cnt_r   <= cnt_r + CNT_W'(1);
    end else begin
      a_sh_r  <= a_sh_r;
      b_sh_r  <= b_sh_r;
      sum_r   <= sum_r;
      carry_r <= carry_r;
      cnt_r   <= cnt_r;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign sum       = sum_r;
  assign carry     = carry_r;

endmodule

// File: tb/tb_multi_word_add_ctrl.sv
// Self-checking bench for multi_word_add_ctrl: vector table, scoreboard queue,
// and hand-written backpressure / reset / back-to-back sequences.
module tb_multi_word_add_ctrl;

  localparam int WIDTH  = 16;
  localparam int NSLICE = WIDTH / 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             busy;
`ifdef MULTI_WORD_ADD_SUB_EN
  logic             sub_in;
`endif

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_carry;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             carry;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[7];
  int   n_cmp;
  int   n_bad;

  multi_word_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .c_in      (c_in),
`ifdef MULTI_WORD_ADD_SUB_EN
    .sub_in    (sub_in),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [WIDTH-1:0] s, input logic c);
    exp_t e;
    e.sum   = s;
    e.carry = c;
    sb_q.push_back(e);
  endtask

  task automatic collect(input string name);
    exp_t e;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: result 0x%0h presented, expected no result", name, sum);
    end else begin
      n_cmp--;
      e = sb_q.pop_front();
      chk({name, "_sum"}, 32'(sum), 32'(e.sum));
      chk({name, "_carry"}, 32'(carry), 32'(e.carry));
    end
  endtask

  // Called #1 after a posedge; returns #1 after the accept edge with in_valid low.
  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic ci,
                          input bit push, input logic [WIDTH-1:0] es, input logic ec);
    int k;
    a_in = a;
    b_in = b;
    c_in = ci;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("accept_ready", 32'(in_ready), 32'd1);
    if (push) push_exp(es, ec);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int k);
    k = 0;
    while (!out_valid && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (!out_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL out_valid_timeout: got 0 after %0d cycles, expected 1", k);
    end
  endtask

  task automatic run_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic ci, input logic [WIDTH-1:0] es, input logic ec);
    int k;
    out_ready = 1'b1;
    start_op(a, b, ci, 1'b1, es, ec);
    wait_out(k);
    chk({name, "_latency"}, 32'(k), 32'(NSLICE));
    collect(name);
    @(posedge clk); #1;
  endtask

  initial begin
    int k;
    int seen;
    int cyc;
    int last_t;
    int sent;
    int got;
    bit acc;
    logic [WIDTH:0] model;

    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a_in = '0;
    b_in = '0;
    c_in = 1'b0;
`ifdef MULTI_WORD_ADD_SUB_EN
    sub_in = 1'b0;
`endif

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
    vecs[2] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[5] = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1};
    vecs[6] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_carry", 32'(carry), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].ci,
             vecs[i].exp_sum, vecs[i].exp_carry);
    end

    // Backpressure: result held while a stray request is ignored.
    out_ready = 1'b0;
    start_op(16'h1111, 16'h2222, 1'b0, 1'b1, 16'h3333, 1'b0);
    wait_out(k);
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_sum", 32'(sum), 32'h3333);
      chk("bp_carry", 32'(carry), 32'd0);
      if (i == 1) begin
        a_in = 16'h0001;
        b_in = 16'h0000;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    collect("bp");
    @(posedge clk); #1;
    chk("bp_idle_valid", 32'(out_valid), 32'd0);
    chk("bp_idle_ready", 32'(in_ready), 32'd1);
    chk("bp_idle_busy", 32'(busy), 32'd0);
    run_op("bp_next", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0);

    // Reset two cycles into RUN abandons the operation.
    start_op(16'h5555, 16'h1111, 1'b0, 1'b0, 16'h0000, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_sum", 32'(sum), 32'd0);
    chk("mid_rst_carry", 32'(carry), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid || !in_ready) seen++;
    end
    chk("mid_rst_quiet", 32'(seen), 32'd0);
    run_op("post_rst", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0);

    // Back-to-back random operations with both handshakes held high.
    out_ready = 1'b1;
    sent = 0;
    got = 0;
    cyc = 0;
    last_t = -1;
    a_in = 16'($urandom);
    b_in = 16'($urandom);
    c_in = 1'($urandom_range(0, 1));
    in_valid = 1'b1;
    while (got < 10 && cyc < 300) begin
      if (out_valid) begin
        collect("b2b");
        if (last_t >= 0) chk("b2b_spacing", 32'(cyc - last_t), 32'd6);
        last_t = cyc;
        got++;
      end
      acc = in_valid && in_ready;
      if (acc) begin
        model = {1'b0, a_in} + {1'b0, b_in} + {{WIDTH{1'b0}}, c_in};
        push_exp(model[WIDTH-1:0], model[WIDTH]);
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        sent++;
        if (sent < 10) begin
          a_in = 16'($urandom);
          b_in = 16'($urandom);
          c_in = 1'($urandom_range(0, 1));
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    chk("b2b_count", 32'(got), 32'd10);
    @(posedge clk); #1;

`ifdef MULTI_WORD_ADD_SUB_EN
    sub_in = 1'b1;
    run_op("sub_pos", 16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1);
    run_op("sub_neg", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0);
    sub_in = 1'b0;
`endif

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
